// File: rtl/i2s_frame_tx_if.sv
// Parallel stereo frame stream into the I2S transmitter.
// s_data packs lane n left at [(2n+1)*IN_W-1 : 2n*IN_W], lane n right in the next IN_W bits.
interface i2s_frame_tx_if #(
  parameter int NUM_LANES = 2,
  parameter int IN_W      = 16
);
  logic                        s_valid;
  logic                        s_ready;
  logic [NUM_LANES*2*IN_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/i2s_frame_tx.sv
// I2S / left-justified serial transmitter: one stereo frame per lane per LRC period,
// shifted out MSB-first on NUM_LANES data lines, with underrun and truncation reporting.
module i2s_frame_tx #(
  parameter int NUM_LANES    = 2,
  parameter int IN_W         = 16,
  parameter int SLOT_W       = 24,
  parameter int SHIFT        = 4,
  parameter int CNT_W        = 12,
  parameter int UNDER_REPEAT = 0
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic                 lrc,
  input  logic                 en,
  input  logic                 i2s_mode,
  i2s_frame_tx_if.slave        s,
  output logic [NUM_LANES-1:0] sd,
  output logic                 frame_start,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 underrun,
  output logic [15:0]          underrun_cnt,
  output logic                 trunc,
  output logic [1:0]           fsm_state
);

  localparam int FW = NUM_LANES * 2 * IN_W;
  localparam int BW = $clog2(SLOT_W + 1);
  localparam logic [BW-1:0] BIT_END = BW'(SLOT_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [1:0]        state;
  logic              lrc_d;
  logic              full;
  logic [FW-1:0]     hold_q;
  logic [FW-1:0]     frame_q;
  logic [FW-1:0]     last_q;
  logic              mode_q;
  logic [BW-1:0]     bit_cnt;
  logic [SLOT_W-1:0] shreg [NUM_LANES];

  logic              fall;
  logic              rise;
  logic              start;
  logic              right_start;
  logic              slot_start;
  logic              cut;
  logic              xfer;
  logic              mode_use;
  logic [FW-1:0]     frame_nx;
  logic [SLOT_W-1:0] slot_word [NUM_LANES];

  function automatic logic [SLOT_W-1:0] form_word(input logic [IN_W-1:0] smp);
    logic signed [SLOT_W-1:0] ext;
    ext = SLOT_W'($signed(smp));
    return ext << SHIFT;
  endfunction

  // Valid/ready: a transfer happens on any bclk edge where s_valid & s_ready; s_ready is
  // simply "holding register empty". While en is low transfers complete but the data is
  // discarded, so the source never stalls on a disabled transmitter.
  assign s.s_ready = ~full;
  assign fsm_state = state;

  always_comb begin
    fall        = lrc_d & ~lrc;
    rise        = ~lrc_d & lrc;
    start       = en & fall;
    right_start = en & rise & (state == ST_LEFT);
    slot_start  = start | right_start;
    cut         = slot_start & (state != ST_IDLE) & (bit_cnt < BIT_END);
    xfer        = s.s_valid & s.s_ready;
    mode_use    = start ? i2s_mode : mode_q;
    if (!start) begin
      frame_nx = frame_q;
    end else if (full) begin
      frame_nx = hold_q;
    end else if (UNDER_REPEAT != 0) begin
      frame_nx = last_q;
    end else begin
      frame_nx = '0;
    end
    // Left words come from the frame being launched, right words from the frame in flight.
    for (int n = 0; n < NUM_LANES; n++) begin
      slot_word[n] = form_word(frame_nx[(2 * n + (start ? 0 : 1)) * IN_W +: IN_W]);
    end
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      state        <= ST_IDLE;
      lrc_d        <= 1'b0;
      full         <= 1'b0;
      hold_q       <= '0;
      frame_q      <= '0;
      last_q       <= '0;
      mode_q       <= 1'b0;
      bit_cnt      <= BIT_END;
      sd           <= '0;
      frame_start  <= 1'b0;
      frame_cnt    <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      trunc        <= 1'b0;
      for (int n = 0; n < NUM_LANES; n++) shreg[n] <= '0;
    end else begin
      lrc_d       <= lrc;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      trunc       <= 1'b0;
      if (!en) begin
        state     <= ST_IDLE;
        sd        <= '0;
        frame_cnt <= '0;
        full      <= 1'b0;
        bit_cnt   <= BIT_END;
      end else begin
        if (start) begin
          state       <= ST_LEFT;
          frame_q     <= frame_nx;
          mode_q      <= i2s_mode;
          frame_start <= 1'b1;
          frame_cnt   <= frame_cnt + 1'b1;
          if (full) begin
            last_q <= hold_q;
          end else begin
            underrun <= 1'b1;
            if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
          end
        end else if (right_start) begin
          state <= ST_RIGHT;
        end
        trunc <= cut;

        // I2S parks one zero bit at the slot edge; left-justified drives the MSB immediately.
        if (slot_start) begin
          for (int n = 0; n < NUM_LANES; n++) begin
            if (mode_use) begin
              sd[n]    <= 1'b0;
              shreg[n] <= slot_word[n];
            end else begin
              sd[n]    <= slot_word[n][SLOT_W-1];
              shreg[n] <= slot_word[n] << 1;
            end
          end
          bit_cnt <= mode_use ? '0 : BW'(1);
        end else if (bit_cnt < BIT_END) begin
          for (int n = 0; n < NUM_LANES; n++) begin
            sd[n]    <= shreg[n][SLOT_W-1];
            shreg[n] <= shreg[n] << 1;
          end
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          sd <= '0;
        end

        // A same-cycle handshake lands after the frame-start check, so it waits for the next frame.
        if (start && full) full <= 1'b0;
        if (xfer) begin
          full   <= 1'b1;
          hold_q <= s.s_data;
        end
      end
    end
  end

endmodule

// File: doc/i2s_frame_tx.md
Name: i2s_frame_tx

Overview:
- Parametrised I2S / left-justified serial transmitter for test and mic-emulation paths.
- Accepts one parallel stereo frame per lane from any sample source (ROM player, filter output) through a valid/ready handshake.
- Sign-extends and shifts each sample into a slot word, then shifts it out MSB-first on NUM_LANES data lines, aligned to an externally supplied LRC.
- Provides a frame counter for ROM addressing, plus underrun and truncation reporting.
- Single clock domain: everything runs on bclk.

Parameters:
- NUM_LANES, 2: number of serial data lines; each carries a left and a right word.
- IN_W, 16: input sample width, two's complement.
- SLOT_W, 24: bits transmitted per slot word. Constraint: IN_W + SHIFT <= SLOT_W.
- SHIFT, 4: left shift applied after sign extension; vacated LSBs are zero.
- CNT_W, 12: width of frame_cnt.
- UNDER_REPEAT, 0: underrun policy. 0 = transmit zeros; 1 = repeat the last accepted frame.

Ports:
- bclk, in, 1: bit clock. The only clock; all flops update on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- lrc, in, 1: word select. Low = left slot, high = right slot. Synchronous to bclk.
- en, in, 1: enable. When low, the block outputs silence and frame_cnt is held at 0.
- i2s_mode, in, 1: 1 = I2S (MSB one bclk after the LRC edge); 0 = left-justified. Sampled at frame start.
- s_valid, in, 1: input frame valid.
- s_ready, out, 1: holding register empty.
- s_data, in, NUM_LANES*2*IN_W: input frame. Lane n left = bits [(2n+1)*IN_W-1 : 2n*IN_W]; lane n right = the next IN_W bits.
- sd, out, NUM_LANES: serial data, one bit per lane.
- frame_start, out, 1: one-cycle pulse on each accepted left-slot start.
- frame_cnt, out, CNT_W: frame counter.
- underrun, out, 1: one-cycle pulse when a frame starts with the holding register empty.
- underrun_cnt, out, 16: saturating count of underruns.
- trunc, out, 1: one-cycle pulse when an LRC edge arrives before the current slot word is fully sent.

Behaviour:
- Reset values: sd = 0, s_ready = 1, frame_start = 0, underrun = 0, trunc = 0, frame_cnt = 0, underrun_cnt = 0. Internal state: lrc_d = 0, armed = 0, holding empty, last frame = 0.
- Edge detect: lrc_d registers lrc. Falling edge = lrc_d & ~lrc. Rising edge = ~lrc_d & lrc. Both are evaluated combinationally in the edge cycle, called E.
- Arming: the state machine is IDLE until the first falling edge while en = 1. Rising edges in IDLE are ignored.
- States: IDLE -> LEFT (on falling edge) -> RIGHT (on rising edge) -> LEFT (on falling edge) ...
- en = 0 in any state forces IDLE, sd = 0, frame_cnt = 0 and flushes the holding register.
- Handshake: a transfer occurs on a cycle with s_valid & s_ready. Data goes to the holding register, which becomes full, so s_ready = 0 on the next cycle. s_ready = !full.
- Frame start (falling edge in LEFT, RIGHT or IDLE with en = 1), all at edge E:
  - If holding is full: the frame register takes the holding contents, holding becomes empty, and last frame is updated.
  - If holding is empty: frame register = zeros (UNDER_REPEAT = 0) or last frame (UNDER_REPEAT = 1). Pulse underrun; underrun_cnt += 1, saturating at 0xFFFF.
  - A handshake in cycle E is written to holding after the frame-start check, so it is not used for this frame.
  - frame_start pulses for one cycle; frame_cnt increments modulo 2^CNT_W; i2s_mode is latched.
- Word formation: each word = sign_extend(sample, SLOT_W) << SHIFT, truncated to SLOT_W bits. Example with defaults: 0x8001 -> 0xF80010; 0x7FFF -> 0x07FFF0.
- Bit timing:
  - A bit counter clears at E on every LRC edge.
  - Left-justified: sd takes word bit SLOT_W-1 at E and bit SLOT_W-1-k at E+k, for k = 0..SLOT_W-1.
  - I2S: sd = 0 at E, then bit SLOT_W-1-(k-1) at E+k, for k = 1..SLOT_W.
  - After the last bit, sd = 0 until the next edge. The LEFT slot sends the left word; the RIGHT slot sends the right word.
- Truncation: if an LRC edge arrives before all SLOT_W bits are out, the remaining bits are dropped, trunc pulses at E, and the new slot starts normally.
- Reset mid-frame: sd = 0 on the next cycle; the block returns to IDLE and waits for a fresh falling edge.

Test Plan:
- Defaults, LJ, 32 bclk per slot. Preload frame with lane 0 L = 0x8001, R = 0x7FFF. At first LRC falling edge: lane 0 sd shifts 0xF80010 over E..E+23, then zeros; frame_start pulses; frame_cnt = 1. Right slot shifts 0x07FFF0.
- Same stimulus with i2s_mode = 1: sd = 0 at E, MSB at E+1, LSB at E+24. Right slot is offset by one bclk in the same way.
- No s_valid before the second frame: underrun pulses and underrun_cnt = 1. sd is all zeros with UNDER_REPEAT = 0; with UNDER_REPEAT = 1 the sd pattern equals frame 1.
- 16 bclk per slot: trunc pulses at every edge; only the top 16 bits of each word appear on sd.
- Deassert en mid-RIGHT slot: sd = 0 next cycle, frame_cnt = 0, s_ready = 1. Re-enable with a rising LRC edge first: the rising edge is ignored and output resumes at the next falling edge.
- Assert rst mid-word: all outputs read their reset values on the next cycle; frame_cnt wrap from 0xFFF to 0x000 is checked separately with 4096 frames.
